// File: rtl/sdram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and helpers for the SDRAM channel arbiters.
//   ADDR_W / DATA_W : channel word-address and data widths
//   MAX_CLIENTS     : largest client count any arbiter may be built with
//   IDX_W           : width of a client index (covers MAX_CLIENTS)
//   arb_state_t     : arbiter FSM states
//   rr_next()       : round-robin pick, returns a one-hot grant
// ----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int ADDR_W      = 26;
    localparam int DATA_W      = 32;
    localparam int MAX_CLIENTS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic {IDLE, WAIT} arb_state_t;

    // First set bit of 'pending' scanning upward from last+1, wrapping at
    // num-1 -> 0. Bits at or above 'num' are never granted.
    function automatic logic [MAX_CLIENTS-1:0] rr_next(
        input logic [MAX_CLIENTS-1:0] pending,
        input logic [IDX_W-1:0]       last,
        input int                     num
    );
        logic [MAX_CLIENTS-1:0] grant;
        logic [IDX_W-1:0]       idx;
        grant = '0;
        for (int k = 1; k <= MAX_CLIENTS; k++) begin
            idx = IDX_W'((int'(last) + k) % num);
            if (k <= num && grant == '0 && pending[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// ----------------------------------------------------------------------------
// sdram_rr_pick
// Combinational round-robin picker shared by the SDRAM channel arbiters.
//   pending    in  NUM_CLIENTS  request-pending flags
//   last_grant in  IDX_W        client granted most recently
//   grant      out IDX_W        index of the chosen client
//   valid      out 1            a client was chosen (any pending bit set)
// ----------------------------------------------------------------------------
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 3
) (
    input  logic [NUM_CLIENTS-1:0] pending,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [IDX_W-1:0]       grant,
    output logic                   valid
);

    logic [MAX_CLIENTS-1:0] onehot;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        onehot = rr_next(MAX_CLIENTS'(pending), last_grant, NUM_CLIENTS);
        grant  = '0;
        valid  = |onehot;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (onehot[i]) begin
                grant = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sdram_ch2_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_ch2_arbiter
// Shares SDRAM controller channel 2 between NUM_CLIENTS requesters. Request
// pulses are latched per client, one client is picked round-robin, a single
// one-cycle ch2_req is issued, and the controller's ready pulse and read data
// are routed back to the owning client one cycle later.
//
// Ports
//   clk, reset            SDRAM clock; asynchronous active-high reset
//   cl_addr/din/rnw/req   per-client request (client i at slice i)
//   cl_dout, cl_ready     per-client read data (held) and completion pulse
//   ch2_addr/din/rnw/req  registered request to the controller
//   ch2_ready, ch2_dout   controller completion pulse and read data
//   arb_timeout           one-cycle watchdog pulse (0 unless enabled)
//
// Optional build macro: SDRAM_ARB_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog
// on the WAIT state.
// ----------------------------------------------------------------------------
module sdram_ch2_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_din,
    input  logic [NUM_CLIENTS-1:0]        cl_rnw,
    input  logic [NUM_CLIENTS-1:0]        cl_req,
    output logic [NUM_CLIENTS*DATA_W-1:0] cl_dout,
    output logic [NUM_CLIENTS-1:0]        cl_ready,
    output logic [ADDR_W-1:0]             ch2_addr,
    output logic [DATA_W-1:0]             ch2_din,
    output logic                          ch2_rnw,
    output logic                          ch2_req,
    input  logic                          ch2_ready,
    input  logic [DATA_W-1:0]             ch2_dout,
    output logic                          arb_timeout
);

    arb_state_t             state, next_state;
    logic [NUM_CLIENTS-1:0] pending, shadow_valid;
    logic [NUM_CLIENTS-1:0] lat_rnw, shadow_rnw;
    logic [ADDR_W-1:0]      lat_addr [NUM_CLIENTS];
    logic [ADDR_W-1:0]      shadow_addr [NUM_CLIENTS];
    logic [DATA_W-1:0]      lat_din [NUM_CLIENTS];
    logic [DATA_W-1:0]      shadow_din [NUM_CLIENTS];
    logic [IDX_W-1:0]       cur, last_grant, pick_idx;
    logic                   pick_valid, launch, done, timeout_hit;
    logic [NUM_CLIENTS-1:0] busy, finish;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_din;
    logic                   sel_rnw;

    sdram_rr_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .grant      (pick_idx),
        .valid      (pick_valid)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               tmo_cnt <= '0;
        else if (launch)         tmo_cnt <= '0;
        else if (state == WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
    end

    // A real ready in the last counted cycle still wins over the watchdog.
    assign timeout_hit = (state == WAIT) && !ch2_ready
                         && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (pick_valid) begin
                launch     = 1'b1;
                next_state = WAIT;
            end
            WAIT: if (ch2_ready || timeout_hit) begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // busy: the client's latch is feeding (or about to feed) the channel, so
    // a fresh request must go to the shadow slot or it would be lost when the
    // completion clears pending.
    always_comb begin
        busy     = '0;
        finish   = '0;
        sel_addr = '0;
        sel_din  = '0;
        sel_rnw  = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            busy[i]   = (state == WAIT && cur == IDX_W'(i))
                        || (launch && pick_idx == IDX_W'(i));
            finish[i] = done && (cur == IDX_W'(i));
            if (pick_idx == IDX_W'(i)) begin
                sel_addr = lat_addr[i];
                sel_din  = lat_din[i];
                sel_rnw  = lat_rnw[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the request latches are tiny register arrays, not RAM, so
            // they are cleared like any other state and hold no stale request.
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                lat_addr[i]    <= '0;
                lat_din[i]     <= '0;
                shadow_addr[i] <= '0;
                shadow_din[i]  <= '0;
            end
            pending      <= '0;
            shadow_valid <= '0;
            lat_rnw      <= '0;
            shadow_rnw   <= '0;
            cur          <= '0;
            last_grant   <= IDX_W'(NUM_CLIENTS - 1);
            ch2_addr     <= '0;
            ch2_din      <= '0;
            ch2_rnw      <= 1'b0;
            ch2_req      <= 1'b0;
            cl_ready     <= '0;
            cl_dout      <= '0;
            arb_timeout  <= 1'b0;
        end else begin
            ch2_req     <= launch;
            cl_ready    <= finish;
            arb_timeout <= timeout_hit;
            if (launch) begin
                ch2_addr <= sel_addr;
                ch2_din  <= sel_din;
                ch2_rnw  <= sel_rnw;
                cur      <= pick_idx;
            end
            if (done) last_grant <= cur;

            for (int i = 0; i < NUM_CLIENTS; i++) begin
                // ch2_rnw is held for the whole access, so it is the in-flight
                // direction; writes and timeouts leave cl_dout untouched.
                if (finish[i] && ch2_ready && ch2_rnw) begin
                    cl_dout[i*DATA_W +: DATA_W] <= ch2_dout;
                end
                if (finish[i]) begin
                    // A request arriving with the completion overrides the
                    // shadow, then the survivor becomes the next pending access.
                    shadow_valid[i] <= 1'b0;
                    if (cl_req[i]) begin
                        lat_addr[i] <= cl_addr[i*ADDR_W +: ADDR_W];
                        lat_din[i]  <= cl_din[i*DATA_W +: DATA_W];
                        lat_rnw[i]  <= cl_rnw[i];
                    end else if (shadow_valid[i]) begin
                        lat_addr[i] <= shadow_addr[i];
                        lat_din[i]  <= shadow_din[i];
                        lat_rnw[i]  <= shadow_rnw[i];
                    end
                    pending[i] <= cl_req[i] || shadow_valid[i];
                end else if (cl_req[i]) begin
                    if (busy[i]) begin
                        shadow_addr[i]  <= cl_addr[i*ADDR_W +: ADDR_W];
                        shadow_din[i]   <= cl_din[i*DATA_W +: DATA_W];
                        shadow_rnw[i]   <= cl_rnw[i];
                        shadow_valid[i] <= 1'b1;
                    end else begin
                        lat_addr[i] <= cl_addr[i*ADDR_W +: ADDR_W];
                        lat_din[i]  <= cl_din[i*DATA_W +: DATA_W];
                        lat_rnw[i]  <= cl_rnw[i];
                        pending[i]  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
